// File: rtl/packet_or_reducer_pkg.sv
// -----------------------------------------------------------------------------
// packet_or_reducer_pkg
//   Shared types and helpers for the packet OR reducer.
//   - state_t      : FSM encoding (ACCUM collects beats, HOLD presents a result)
//   - DEF_WIDTH    : default number of data lanes per beat
//   - DEF_CNT_W    : default beat-counter width
//   - sat_inc()    : increment that sticks at a caller-supplied maximum
// -----------------------------------------------------------------------------
package packet_or_reducer_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  // Works on a 32-bit carrier so one function serves any counter width up to
  // 32; callers cast in and out of their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/packet_or_reducer_or_lane_mux.sv
// -----------------------------------------------------------------------------
// or_lane_mux
//   One-bit OR gate built only from 2:1 multiplexer cells whose data inputs are
//   tied to constants or to the previous mux stage.
//   Ports:
//     a, b : operands
//     y    : a | b
// -----------------------------------------------------------------------------
module or_lane_mux (
  input  logic a,
  input  logic b,
  output logic y
);

  logic b_buf;

  // First cell turns b into a mux-driven copy (sel=b, d1=1, d0=0), second cell
  // forces 1 when a is set and otherwise passes b through (sel=a, d1=1, d0=b).
  assign b_buf = b ? 1'b1 : 1'b0;
  assign y     = a ? 1'b1 : b_buf;

endmodule

// File: rtl/packet_or_reducer.sv
// -----------------------------------------------------------------------------
// packet_or_reducer
//   Consumes WIDTH-bit beats grouped into packets and emits one result per
//   packet: the bitwise OR of every beat, its reduction OR and the beat count
//   (saturating at 2^CNT_W-1).
//
//   Handshake rule (both sides): a transfer happens on a rising edge where
//   valid and ready are both high. Valid never depends on ready; in_ready
//   depends only on state, out_ready and rst, never on in_valid.
//
//   Optional build macro:
//     PACKET_OR_REDUCER_ZERO_DROP_EN - packets whose OR is all-zero produce no
//                                      result (no HOLD, no out_valid).
//
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     in_valid/in_ready     : beat handshake
//     in_data, in_last      : beat payload and end-of-packet flag
//     out_valid/out_ready   : result handshake
//     out_data              : OR of all beats in the packet
//     out_any               : |out_data
//     out_beats             : saturating beat count of the packet
//     dbg_state             : current FSM state for observation
// -----------------------------------------------------------------------------
module packet_or_reducer
  import packet_or_reducer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic [CNT_W-1:0] out_beats,
  output state_t           dbg_state
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] acc_or;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat_take;
  logic             pkt_done;
  logic             drop_zero;
  logic             emit;

  // Per-lane combine of the running accumulator with the incoming beat.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    or_lane_mux u_or (
      .a (acc[i]),
      .b (in_data[i]),
      .y (acc_or[i])
    );
  end

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), CNT_MAX));

`ifdef PACKET_OR_REDUCER_ZERO_DROP_EN
  assign drop_zero = ~|acc_or;
`else
  assign drop_zero = 1'b0;
`endif

  // HOLD can only accept a beat in the cycle its result is being drained.
  assign in_ready  = ~rst & ((state == ACCUM) | out_ready);
  assign beat_take = in_valid & in_ready;
  assign pkt_done  = beat_take & in_last;
  assign emit      = pkt_done & ~drop_zero;

  assign out_valid = (state == HOLD);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_any   <= 1'b0;
      out_beats <= '0;
    end else begin
      // Datapath: acc/cnt are always zero at packet start, including the
      // first beat taken during a HOLD drain cycle.
      if (beat_take) begin
        if (in_last) begin
          acc <= '0;
          cnt <= '0;
          if (!drop_zero) begin
            out_data  <= acc_or;
            out_any   <= |acc_or;
            out_beats <= cnt_inc;
          end
        end else begin
          acc <= acc_or;
          cnt <= cnt_inc;
        end
      end

      unique case (state)
        ACCUM: begin
          if (emit) state <= HOLD;
        end
        HOLD: begin
          // Draining: a same-cycle single-beat packet reloads and keeps HOLD.
          if (out_ready) state <= emit ? HOLD : ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_or_reducer.sv
// -----------------------------------------------------------------------------
// tb_packet_or_reducer
//   Directed vectors for the packet OR reducer plus a randomised stream
//   against an expected-result queue. Inputs are driven and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_packet_or_reducer;
  import packet_or_reducer_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int W     = WIDTH + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic             in_valid, in_ready, in_last, out_valid, out_ready, out_any;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CNT_W-1:0] out_beats;
  state_t           dbg_state;

  packet_or_reducer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_any   (out_any),
    .out_beats (out_beats),
    .dbg_state (dbg_state)
  );

  // ---------------- narrow-counter DUT ----------------
  logic       s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_any;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_out_beats;
  state_t     s_dbg_state;

  packet_or_reducer #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_any   (s_out_any),
    .out_beats (s_out_beats),
    .dbg_state (s_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic sat_beat(input logic [7:0] d, input logic l);
    s_in_valid = 1'b1;
    s_in_data  = d;
    s_in_last  = l;
    @(negedge clk);
    s_in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]   cur_data;
    logic [7:0]   m_acc;
    logic [CNT_W-1:0] m_cnt;
    logic [W-1:0] e;
    int           pkts_left;
    int           beats_left;
    int           cycles;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_beats", 32'(out_beats), 32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Three-beat packet, consumer always ready.
    cyc(1'b1, 8'h01, 1'b0, 1'b1);
    cyc(1'b1, 8'h10, 1'b0, 1'b1);
    check("p3_mid_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 8'h80, 1'b1, 1'b1);
    check("p3_valid", 32'(out_valid), 32'd1);
    check("p3_data",  32'(out_data),  32'h91);
    check("p3_any",   32'(out_any),   32'd1);
    check("p3_beats", 32'(out_beats), 32'd3);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("p3_drained", 32'(out_valid), 32'd0);

    // Single all-zero beat.
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
`ifdef PACKET_OR_REDUCER_ZERO_DROP_EN
    check("zero_valid", 32'(out_valid), 32'd0);
    check("zero_ready", 32'(in_ready),  32'd1);
`else
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_data",  32'(out_data),  32'h00);
    check("zero_any",   32'(out_any),   32'd0);
    check("zero_beats", 32'(out_beats), 32'd1);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("zero_drained", 32'(out_valid), 32'd0);

    // Back-pressure with a concurrent beat on the drain cycle.
    cyc(1'b1, 8'h0F, 1'b1, 1'b0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data",  32'(out_data),  32'h0F);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1; out_ready = 1'b0;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data",  32'(out_data),  32'h0F);
      check("bp_hold_beats", 32'(out_beats), 32'd1);
    end
    in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_drain_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_data",  32'(out_data),  32'hF0);
    check("b2b_beats", 32'(out_beats), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Mid-packet reset discards the partial accumulation.
    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data",  32'(out_data),  32'd0);
    check("mrst_any",   32'(out_any),   32'd0);
    check("mrst_beats", 32'(out_beats), 32'd0);
    check("mrst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    cyc(1'b1, 8'h01, 1'b1, 1'b1);
    check("mrst_pkt_data",  32'(out_data),  32'h01);
    check("mrst_pkt_beats", 32'(out_beats), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Saturating count on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) sat_beat(8'(1 << i), 1'b0);
    sat_beat(8'h20, 1'b1);
    check("sat6_valid", 32'(s_out_valid), 32'd1);
    check("sat6_beats", 32'(s_out_beats), 32'd3);
    check("sat6_data",  32'(s_out_data),  32'h3F);
    @(negedge clk);
    sat_beat(8'h40, 1'b0);
    sat_beat(8'h00, 1'b1);
    check("sat2_beats", 32'(s_out_beats), 32'd2);
    check("sat2_data",  32'(s_out_data),  32'h40);

    // Random packet stream with random valid/ready.
    pkts_left  = 30;
    beats_left = $urandom_range(1, 20);
    m_acc      = '0;
    m_cnt      = '0;
    cur_data   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
    cycles     = 0;
    while ((pkts_left > 0 || exp_q.size() > 0) && cycles < 5000) begin
      cycles++;
      out_ready = (pkts_left == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (pkts_left > 0) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = cur_data;
        in_last  = (beats_left == 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_data",  32'(out_data),  32'(e[W-1:CNT_W]));
          check("rnd_beats", 32'(out_beats), 32'(e[CNT_W-1:0]));
          check("rnd_any",   32'(out_any),   32'(|e[W-1:CNT_W]));
        end
      end
      if (in_valid && in_ready) begin
        m_acc = m_acc | cur_data;
        m_cnt = m_cnt + 1'b1;
        if (in_last) begin
`ifdef PACKET_OR_REDUCER_ZERO_DROP_EN
          if (m_acc != 8'h00) exp_q.push_back({m_acc, m_cnt});
`else
          exp_q.push_back({m_acc, m_cnt});
`endif
          m_acc      = '0;
          m_cnt      = '0;
          pkts_left--;
          beats_left = $urandom_range(1, 20);
        end else begin
          beats_left--;
        end
        cur_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      end
      @(negedge clk);
    end
    check("rnd_pkts_sent", 32'(pkts_left),    32'd0);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
